crc_stream_engine: RTL

Parametrised, streaming CRC engine that generalises the fixed 64-bit/CRC-16 parallel update in width, polynomial, init and final XOR.
- Sits inline on a valid/ready data path between a frame source (e.g. hit/waveform packer) and the link serializer.
- Computes the CRC per frame, honours a partial final word, and optionally appends the CRC as an extra beat.
- Reports the finished CRC and a wrapping frame count.

---
 rtl/crc_stream_engine_if.sv | 31 +++
 rtl/crc_stream_engine.sv | 121 ++++++++++++
 2 files changed

// File: rtl/crc_stream_engine_if.sv
// Valid/ready stream bundle around the CRC engine: upstream frame beats in,
// downstream beats (data plus optional appended CRC) out.
interface crc_stream_engine_if #(
  parameter int DATA_W = 64
);
  localparam int NB_W = (DATA_W / 8 > 1) ? $clog2(DATA_W / 8) : 1;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic [NB_W-1:0]   s_nbytes;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [NB_W-1:0]   m_nbytes;
  logic              m_last;
  logic              m_is_crc;

  // master = frame source / sink side, slave = the engine
  modport master (
    output s_valid, s_data, s_last, s_nbytes, m_ready,
    input  s_ready, m_valid, m_data, m_nbytes, m_last, m_is_crc
  );

  modport slave (
    input  s_valid, s_data, s_last, s_nbytes, m_ready,
    output s_ready, m_valid, m_data, m_nbytes, m_last, m_is_crc
  );
endinterface

// File: rtl/crc_stream_engine.sv
// Inline streaming CRC engine: folds each accepted beat into a running CRC,
// reports the per-frame result and can append it as an extra output beat.
module crc_stream_engine #(
  parameter int              DATA_W    = 64,
  parameter int              CRC_W     = 16,
  parameter logic [CRC_W-1:0] POLY     = 16'h8005,
  parameter logic [CRC_W-1:0] INIT     = 16'hFFFF,
  parameter logic [CRC_W-1:0] XOR_OUT  = 16'h0000,
  parameter bit              APPEND_EN = 1'b1,
  parameter int              CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  crc_stream_engine_if.slave   bus,
  output logic                 crc_done,
  output logic [CRC_W-1:0]     crc_value,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam int NB_W = (DATA_W / 8 > 1) ? $clog2(DATA_W / 8) : 1;
  localparam logic [NB_W-1:0] CRC_NB = NB_W'((CRC_W / 8) % (DATA_W / 8));

  typedef enum logic [1:0] {IDLE, ACTIVE, APPEND} state_t;

  state_t              state_q, state_d;
  logic [CRC_W-1:0]    crc_q, crc_next;
  int                  fold_bits;
  logic                out_free, accept, load_crc;

  logic                m_valid_q, m_last_q, m_is_crc_q;
  logic [DATA_W-1:0]   m_data_q;
  logic [NB_W-1:0]     m_nbytes_q;

  // Bit-serial CRC unrolled across the beat; bits at or above nbits are skipped.
  function automatic logic [CRC_W-1:0] crc_fold(input logic [CRC_W-1:0] c_in,
                                                input logic [DATA_W-1:0] d,
                                                input int nbits);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = c_in;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < nbits) begin
        fb = c[CRC_W-1] ^ d[i];
        c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
    end
    return c;
  endfunction

  assign out_free     = !m_valid_q || bus.m_ready;
  assign bus.s_ready  = (state_q != APPEND) && out_free;
  assign accept       = bus.s_valid && bus.s_ready;
  assign load_crc     = (state_q == APPEND) && out_free;

  assign fold_bits = (bus.s_last && (bus.s_nbytes != '0)) ? 8 * int'(bus.s_nbytes) : DATA_W;
  assign crc_next  = crc_fold(crc_q, bus.s_data, fold_bits);

  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = m_data_q;
  assign bus.m_nbytes = m_nbytes_q;
  assign bus.m_last   = m_last_q;
  assign bus.m_is_crc = m_is_crc_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A last beat jumps straight to APPEND (or IDLE) even from IDLE, so
  // single-beat frames need no special casing.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (bus.s_last) state_d = APPEND_EN ? APPEND : IDLE;
      else            state_d = ACTIVE;
    end else if (load_crc) begin
      state_d = IDLE;
    end
  end

  // Single registered output stage; registers only change when the stage is free.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q      <= INIT;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_nbytes_q <= '0;
      m_last_q   <= 1'b0;
      m_is_crc_q <= 1'b0;
      crc_done   <= 1'b0;
      crc_value  <= '0;
      frame_cnt  <= '0;
    end else begin
      crc_done <= 1'b0;
      if (accept) begin
        m_data_q   <= bus.s_data;
        m_nbytes_q <= bus.s_last ? bus.s_nbytes : '0;
        m_last_q   <= bus.s_last && !APPEND_EN;
        m_is_crc_q <= 1'b0;
        m_valid_q  <= 1'b1;
        if (bus.s_last) begin
          crc_value <= crc_next ^ XOR_OUT;
          crc_done  <= 1'b1;
          crc_q     <= INIT;
          frame_cnt <= frame_cnt + CNT_W'(1);
        end else begin
          crc_q <= crc_next;
        end
      end else if (load_crc) begin
        m_data_q   <= DATA_W'(crc_value);
        m_nbytes_q <= CRC_NB;
        m_last_q   <= 1'b1;
        m_is_crc_q <= 1'b1;
        m_valid_q  <= 1'b1;
      end else if (bus.m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

endmodule
